vga_timing_stream_sink: RTL

- Consumer side of the VGA pixel clock. Runs on the 25.175 MHz PLL output and qualifies operation with the PLL locked flag.
- Generates 640x480@60 raster timing (hsync, vsync, blank).
- Pulls RGB pixels from an Avalon-ST sink in raster order, with frame alignment on startofpacket.
- Sits between the pixel-buffer DMA stream and the VGA DAC pins.

---
 rtl/vga_timing_stream_sink.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_stream_sink.sv
// 640x480@60 raster generator that pulls RGB beats from an Avalon-ST sink.
// Raster starts after a stable PLL lock and locks onto the stream at startofpacket.
module vga_timing_stream_sink #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int LOCK_WAIT = 16,
    parameter int DW        = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_locked,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          in_ready,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic [DW-1:0] vga_rgb,
    output logic [9:0]    pix_x,
    output logic [9:0]    pix_y,
    output logic          frame_start,
    output logic          underflow,
    output logic          running
);

    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam int         LCW = $clog2(LOCK_WAIT + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            lock_meta_q, lock_sync_q;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [9:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic            aligned_q, aligned_d;
    logic            hold_full_q, hold_full_d;
    logic [DW-1:0]   hold_data_q, hold_data_d;
    logic            in_ready_q, in_ready_d;
    logic            vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
    logic            vga_blank_n_q, vga_blank_n_d;
    logic [DW-1:0]   vga_rgb_q, vga_rgb_d;
    logic [9:0]      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic            frame_start_q, frame_start_d;
    logic            underflow_q, underflow_d;
    logic            running_q, running_d;
    logic            accept_s, at_origin_s, active_s;

    // Ready for the given raster position; registered so it never looks at in_valid.
    function automatic logic ready_fn(input logic [9:0] h, input logic [9:0] v,
                                      input logic aligned, input logic hold_full);
        logic act;
        logic org;
        logic rdy;
        act = (h < HA) && (v < VA);
        org = (h == 10'd0) && (v == 10'd0);
        if (aligned) begin
            rdy = act && !(org && hold_full);
        end else begin
            rdy = (v >= VA);
        end
        return rdy;
    endfunction

    assign accept_s    = in_ready_q && in_valid;
    assign at_origin_s = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign active_s    = (h_cnt_q < HA) && (v_cnt_q < VA);

    // Next-state, raster counters, stream alignment and output pipeline.
    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        aligned_d     = aligned_q;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        underflow_d   = underflow_q;
        vga_hs_d      = 1'b1;
        vga_vs_d      = 1'b1;
        vga_blank_n_d = 1'b0;
        vga_rgb_d     = '0;
        pix_x_d       = 10'd0;
        pix_y_d       = 10'd0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        in_ready_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d     = 10'd0;
                v_cnt_d     = 10'd0;
                aligned_d   = 1'b0;
                hold_full_d = 1'b0;
                underflow_d = 1'b0;
                if (lock_sync_q) begin
                    state_d    = ST_WAIT;
                    lock_cnt_d = LCW'(1);
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                h_cnt_d     = 10'd0;
                v_cnt_d     = 10'd0;
                aligned_d   = 1'b0;
                hold_full_d = 1'b0;
                underflow_d = 1'b0;
                if (!lock_sync_q) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q >= LOCK_LAST) begin
                    state_d    = ST_RUN;
                    lock_cnt_d = '0;
                    running_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_sync_q) begin
                    state_d     = ST_IDLE;
                    h_cnt_d     = 10'd0;
                    v_cnt_d     = 10'd0;
                    aligned_d   = 1'b0;
                    hold_full_d = 1'b0;
                    underflow_d = 1'b0;
                end else begin
                    running_d = 1'b1;
                    if (h_cnt_q == HL) begin
                        h_cnt_d = 10'd0;
                        if (v_cnt_q == VL) begin
                            v_cnt_d = 10'd0;
                        end else begin
                            v_cnt_d = v_cnt_q + 10'd1;
                        end
                    end else begin
                        h_cnt_d = h_cnt_q + 10'd1;
                    end
                    vga_hs_d      = !((h_cnt_q >= HS0) && (h_cnt_q < HS1));
                    vga_vs_d      = !((v_cnt_q >= VS0) && (v_cnt_q < VS1));
                    vga_blank_n_d = active_s;
                    pix_x_d       = h_cnt_q;
                    pix_y_d       = v_cnt_q;
                    frame_start_d = at_origin_s;
                    // A starved pixel is skipped, not stalled: the pending beat lands on the next pixel.
                    if (aligned_q && hold_full_q && at_origin_s) begin
                        vga_rgb_d   = hold_data_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s && !aligned_q) begin
                        if (in_sop) begin
                            hold_data_d = in_data;
                            hold_full_d = 1'b1;
                            aligned_d   = 1'b1;
                        end else begin
                            hold_full_d = hold_full_q;
                        end
                    end else if (accept_s) begin
                        if (in_sop && !at_origin_s) begin
                            aligned_d   = 1'b0;
                            hold_full_d = 1'b0;
                        end else begin
                            vga_rgb_d = in_data;
                        end
                    end else if (in_ready_q && aligned_q && active_s) begin
                        underflow_d = 1'b1;
                    end else begin
                        underflow_d = underflow_q;
                    end
                    in_ready_d = ready_fn(h_cnt_d, v_cnt_d, aligned_d, hold_full_d);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                lock_cnt_d  = '0;
                h_cnt_d     = 10'd0;
                v_cnt_d     = 10'd0;
                aligned_d   = 1'b0;
                hold_full_d = 1'b0;
                underflow_d = 1'b0;
            end
        endcase
    end

    // Lock synchronizer and all state/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q   <= 1'b0;
            lock_sync_q   <= 1'b0;
            state_q       <= ST_IDLE;
            lock_cnt_q    <= '0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            aligned_q     <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            in_ready_q    <= 1'b0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            vga_rgb_q     <= '0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            lock_meta_q   <= pll_locked;
            lock_sync_q   <= lock_meta_q;
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            aligned_q     <= aligned_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            in_ready_q    <= in_ready_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_blank_n_q <= vga_blank_n_d;
            vga_rgb_q     <= vga_rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            running_q     <= running_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;
    assign vga_rgb     = vga_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign running     = running_q;

endmodule
